// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keyboard_pkg
// Purpose  : Shared types and scan-code constants for the PS/2 key decoders
//            of the donkey movement controller.
// Contents : KEY_STATE_T decoder state enum, prefix/scan-code constants,
//            arrow flag indices, default prefix timeout, prefix helper.
// Revision : 1.0 - initial release
// ============================================================================
package keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } KEY_STATE_T;

  localparam logic [7:0] KEY_PREFIX_EXT      = 8'hE0;
  localparam logic [7:0] KEY_PREFIX_BRK      = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] KEY_CODE_LEFT       = 8'h6B;
  localparam logic [7:0] KEY_CODE_RIGHT      = 8'h74;
  localparam logic [7:0] KEY_CODE_UP         = 8'h75;
  localparam logic [7:0] KEY_CODE_DOWN       = 8'h72;
  // Plain space bar
  localparam logic [7:0] KEY_CODE_JUMP       = 8'h29;
  // Plain WASD aliases
  localparam logic [7:0] KEY_CODE_WASD_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_CODE_WASD_RIGHT = 8'h23;
  localparam logic [7:0] KEY_CODE_WASD_UP    = 8'h1D;
  localparam logic [7:0] KEY_CODE_WASD_DOWN  = 8'h1B;

  // Bit positions inside the 4-bit direction flag vectors
  localparam int KEY_DIR_LEFT  = 0;
  localparam int KEY_DIR_RIGHT = 1;
  localparam int KEY_DIR_UP    = 2;
  localparam int KEY_DIR_DOWN  = 3;

  // 10 ms at 65 MHz
  localparam int KEY_TIMEOUT_CYCLES_DEFAULT = 650_000;

  function automatic logic key_is_prefix(input logic [7:0] code);
    return (code == KEY_PREFIX_EXT) || (code == KEY_PREFIX_BRK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_prefix_timer.sv
`default_nettype none
// ============================================================================
// Module   : key_prefix_timer
// Purpose  : Saturating cycle counter that flags when a scan-code prefix has
//            been waiting too long for its following byte.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            run      - count this cycle (decoder waiting after a prefix)
//            restart  - clear the count (byte received / decoder idle)
//            expired  - count has reached TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
// ============================================================================
module key_prefix_timer
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = KEY_TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holds at the limit rather than wrapping, so a stalled decoder can never
  // see the count roll back under the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != c_LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/donkey_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : donkey_key_decoder
// Purpose  : Decodes the PS/2 scan-code byte stream (make, F0 break, E0
//            extended) into held-key levels for the donkey movement FSM.
//            A prefix timeout returns a truncated sequence to idle.
// Ports    : clk       - system clock
//            rst_n     - asynchronous active-low reset
//            rx_data   - received scan-code byte (valid with rx_valid)
//            rx_valid  - one-cycle strobe per received byte
//            clr       - synchronous clear of key levels and decoder state
//            left/right/jump/up/down - registered held-key levels
//            seq_err   - one-cycle pulse on prefix timeout / bad prefix order
// Options  : DONKEY_KEY_WASD_EN - also map plain A/D/W/S to left/right/up/down
// Revision : 1.0 - initial release
// ============================================================================
module donkey_key_decoder
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = KEY_TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clr,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       up,
  output logic       down,
  output logic       seq_err
);

  KEY_STATE_T r_state;
  KEY_STATE_T w_state_nxt;
  logic [3:0] r_arrow;
  logic [3:0] w_arrow_nxt;
  logic       r_jump;
  logic       w_jump_nxt;
  logic       r_seq_err;
  logic       w_seq_err_nxt;
`ifdef DONKEY_KEY_WASD_EN
  logic [3:0] r_wasd;
  logic [3:0] w_wasd_nxt;
  logic [3:0] r_dir;
`endif

  logic w_expired;
  logic w_timer_run;
  logic w_timer_restart;
  logic w_timeout;
  logic w_apply;   // final byte of a sequence: update a key level
  logic w_ext;     // that byte was E0-prefixed
  logic w_level;   // 1 = make, 0 = break

  assign w_timer_run     = (r_state != ST_IDLE);
  assign w_timer_restart = rx_valid || clr || (r_state == ST_IDLE);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_timeout       = w_expired && (r_state != ST_IDLE) && !rx_valid;

  key_prefix_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_prefix_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_timer_run),
    .restart (w_timer_restart),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_arrow_nxt   = r_arrow;
    w_jump_nxt    = r_jump;
    w_seq_err_nxt = 1'b0;
`ifdef DONKEY_KEY_WASD_EN
    w_wasd_nxt    = r_wasd;
`endif
    w_apply       = 1'b0;
    w_ext         = 1'b0;
    w_level       = 1'b0;

    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_arrow_nxt = '0;
      w_jump_nxt  = 1'b0;
`ifdef DONKEY_KEY_WASD_EN
      w_wasd_nxt  = '0;
`endif
    end else if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == KEY_PREFIX_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (rx_data == KEY_PREFIX_BRK) begin
            w_state_nxt = ST_BREAK;
          end else begin
            w_apply = 1'b1;
            w_level = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == KEY_PREFIX_BRK) begin
            w_state_nxt = ST_EXT_BREAK;
          end else if (rx_data == KEY_PREFIX_EXT) begin
            w_state_nxt = ST_EXT;   // repeated E0 is harmless
          end else begin
            w_state_nxt = ST_IDLE;
            w_apply     = 1'b1;
            w_ext       = 1'b1;
            w_level     = 1'b1;
          end
        end
        ST_BREAK: begin
          w_state_nxt = ST_IDLE;
          if (key_is_prefix(rx_data)) begin
            w_seq_err_nxt = 1'b1;
          end else begin
            w_apply = 1'b1;
          end
        end
        ST_EXT_BREAK: begin
          w_state_nxt = ST_IDLE;
          if (key_is_prefix(rx_data)) begin
            w_seq_err_nxt = 1'b1;
          end else begin
            w_apply = 1'b1;
            w_ext   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt   = ST_IDLE;
      w_seq_err_nxt = 1'b1;
    end

    // Key map; anything not listed falls through silently.
    if (w_apply) begin
      if (w_ext) begin
        case (rx_data)
          KEY_CODE_LEFT:  w_arrow_nxt[KEY_DIR_LEFT]  = w_level;
          KEY_CODE_RIGHT: w_arrow_nxt[KEY_DIR_RIGHT] = w_level;
          KEY_CODE_UP:    w_arrow_nxt[KEY_DIR_UP]    = w_level;
          KEY_CODE_DOWN:  w_arrow_nxt[KEY_DIR_DOWN]  = w_level;
          default: ;
        endcase
      end else begin
        if (rx_data == KEY_CODE_JUMP) begin
          w_jump_nxt = w_level;
        end
`ifdef DONKEY_KEY_WASD_EN
        case (rx_data)
          KEY_CODE_WASD_LEFT:  w_wasd_nxt[KEY_DIR_LEFT]  = w_level;
          KEY_CODE_WASD_RIGHT: w_wasd_nxt[KEY_DIR_RIGHT] = w_level;
          KEY_CODE_WASD_UP:    w_wasd_nxt[KEY_DIR_UP]    = w_level;
          KEY_CODE_WASD_DOWN:  w_wasd_nxt[KEY_DIR_DOWN]  = w_level;
          default: ;
        endcase
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_arrow   <= '0;
      r_jump    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arrow   <= w_arrow_nxt;
      r_jump    <= w_jump_nxt;
      r_seq_err <= w_seq_err_nxt;
    end
  end

`ifdef DONKEY_KEY_WASD_EN
  // Arrow and WASD flags are kept apart so releasing one alias leaves the
  // other held. The merged output register is loaded from the next-state
  // flags, so the OR adds no cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wasd <= '0;
      r_dir  <= '0;
    end else begin
      r_wasd <= w_wasd_nxt;
      r_dir  <= w_arrow_nxt | w_wasd_nxt;
    end
  end

  assign left  = r_dir[KEY_DIR_LEFT];
  assign right = r_dir[KEY_DIR_RIGHT];
  assign up    = r_dir[KEY_DIR_UP];
  assign down  = r_dir[KEY_DIR_DOWN];
`else
  assign left  = r_arrow[KEY_DIR_LEFT];
  assign right = r_arrow[KEY_DIR_RIGHT];
  assign up    = r_arrow[KEY_DIR_UP];
  assign down  = r_arrow[KEY_DIR_DOWN];
`endif

  assign jump    = r_jump;
  assign seq_err = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_donkey_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_donkey_key_decoder
// Purpose  : Self-checking bench for donkey_key_decoder: directed vector
//            table, hand-written timeout/reset/clear sequences, and random
//            byte streams checked against a held-scan-code reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_donkey_key_decoder;

  localparam int T = 16;
`ifdef DONKEY_KEY_WASD_EN
  localparam bit WASD = 1'b1;
`else
  localparam bit WASD = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clr      = 1'b0;
  logic       left, right, jump, up, down, seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  donkey_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .clr      (clr),
    .left     (left),
    .right    (right),
    .jump     (jump),
    .up       (up),
    .down     (down),
    .seq_err  (seq_err)
  );

  // ---------------- reference model ----------------
  // Tracks which scan codes are currently held (plain and extended sets)
  // and the list of pending prefix bytes; outputs are derived from the sets.
  bit         m_ext   [256];
  bit         m_plain [256];
  logic [7:0] m_pend  [$];
  int         m_wait;
  bit         m_err;

  function automatic bit pend_has(input logic [7:0] v);
    foreach (m_pend[i]) if (m_pend[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_ext[i]   = 1'b0;
      m_plain[i] = 1'b0;
    end
    m_pend.delete();
    m_wait = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit v, input logic [7:0] d);
    bit ext, brk;
    m_err = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      m_wait = 0;
      if (d == 8'hE0 || d == 8'hF0) begin
        if (pend_has(8'hF0)) begin
          m_err = 1'b1;
          m_pend.delete();
        end else if (d == 8'hF0 || m_pend.size() == 0) begin
          m_pend.push_back(d);
        end
      end else begin
        ext = pend_has(8'hE0);
        brk = pend_has(8'hF0);
        if (ext) m_ext[d] = !brk;
        else     m_plain[d] = !brk;
        m_pend.delete();
      end
    end else if (m_pend.size() != 0) begin
      if (m_wait == T - 1) begin
        m_err = 1'b1;
        m_pend.delete();
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  function automatic logic [5:0] model_out();
    return {m_ext[8'h6B] | (WASD & m_plain[8'h1C]),
            m_ext[8'h74] | (WASD & m_plain[8'h23]),
            m_plain[8'h29],
            m_ext[8'h75] | (WASD & m_plain[8'h1D]),
            m_ext[8'h72] | (WASD & m_plain[8'h1B]),
            m_err};
  endfunction

  // ---------------- drive / check ----------------
  task automatic apply(input bit c, input bit v, input logic [7:0] d);
    clr      = c;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(c, v, d);
    #1;
    clr      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check(input string name, input int idx, input logic [5:0] exp);
    logic [5:0] act;
    act = {left, right, jump, up, down, seq_err};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: {L,R,J,U,D,E} got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic send(input string name, input logic [7:0] d, input logic [5:0] exp);
    apply(1'b0, 1'b1, d);
    check(name, 0, exp);
  endtask

  task automatic idle(input string name, input logic [5:0] exp);
    apply(1'b0, 1'b0, 8'h00);
    check(name, 0, exp);
  endtask

  // Async reset pulse between edges; outputs must drop while it is low.
  task automatic pulse_reset(input string name);
    #1 rst_n = 1'b0;
    model_reset();
    #2 check(name, 0, 6'b000000);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit         c;
    bit         v;
    logic [7:0] d;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit c, input bit v, input logic [7:0] d,
                              input logic [5:0] exp);
    vec_t e;
    e.c = c; e.v = v; e.d = d; e.exp = exp;
    vt.push_back(e);
  endfunction

  function automatic void b(input logic [7:0] d, input logic [5:0] exp);
    add(1'b0, 1'b1, d, exp);
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] pool [12];

  initial begin
    model_reset();
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72,
             8'h29, 8'h1C, 8'h23, 8'h1D, 8'h1B, 8'hAA};

    // {L,R,J,U,D,E}
    // E0 6B make, E0 F0 6B break
    b(8'hE0, 6'b000000); b(8'h6B, 6'b100000); add(0, 0, 8'h00, 6'b100000);
    b(8'hE0, 6'b100000); b(8'hF0, 6'b100000); b(8'h6B, 6'b000000);
    // typematic space, then release
    for (int i = 0; i < 5; i++) b(8'h29, 6'b001000);
    b(8'hF0, 6'b001000); b(8'h29, 6'b000000);
    // left and right together
    b(8'hE0, 6'b000000); b(8'h74, 6'b010000);
    b(8'hE0, 6'b010000); b(8'h6B, 6'b110000);
    b(8'hE0, 6'b110000); b(8'hF0, 6'b110000); b(8'h74, 6'b100000);
    b(8'hE0, 6'b100000); b(8'hF0, 6'b100000); b(8'h6B, 6'b000000);
    // up / down
    b(8'hE0, 6'b000000); b(8'h75, 6'b000100);
    b(8'hE0, 6'b000100); b(8'h72, 6'b000110);
    b(8'hE0, 6'b000110); b(8'hF0, 6'b000110); b(8'h75, 6'b000010);
    b(8'hE0, 6'b000010); b(8'hF0, 6'b000010); b(8'h72, 6'b000000);
    // unmapped plain / special codes, no seq_err
    b(8'h75, 0); b(8'h6B, 0); b(8'h72, 0); b(8'h74, 0);
    b(8'hAA, 0); b(8'hFA, 0); b(8'hFE, 0); b(8'hEE, 0);
    b(8'hF0, 0); b(8'hAA, 0);
    b(8'hE0, 0); b(8'h29, 0);        // extended 29 is not jump
    // duplicate E0
    b(8'hE0, 0); b(8'hE0, 0); b(8'h6B, 6'b100000);
    b(8'hE0, 6'b100000); b(8'hF0, 6'b100000); b(8'h6B, 0);
    // illegal prefix orders
    b(8'hF0, 0); b(8'hF0, 6'b000001); add(0, 0, 8'h00, 0);
    b(8'hF0, 0); b(8'hE0, 6'b000001);
    b(8'hE0, 0); b(8'hF0, 0); b(8'hE0, 6'b000001);
    b(8'hE0, 0); b(8'hF0, 0); b(8'hF0, 6'b000001);
    b(8'h29, 6'b001000);             // back in idle: plain make
    b(8'hF0, 6'b001000); b(8'hF0, 6'b001001); // error leaves jump held
    b(8'h29, 6'b001000); b(8'hF0, 6'b001000); b(8'h29, 0);
    // clr
    b(8'hE0, 0); add(1, 1, 8'h6B, 0); b(8'h6B, 0);
    b(8'h29, 6'b001000); b(8'hE0, 6'b001000); b(8'h74, 6'b011000);
    add(1, 0, 8'h00, 0);
    b(8'hF0, 0); add(1, 1, 8'h29, 0); b(8'h29, 6'b001000);
    b(8'hF0, 6'b001000); b(8'h29, 0);

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 0, 6'b000000);
    rst_n = 1'b1;
    idle("post_reset_idle", 6'b000000);

    foreach (vt[i]) begin
      apply(vt[i].c, vt[i].v, vt[i].d);
      check("vec", i, vt[i].exp);
    end

    // prefix timeout from ST_EXT
    send("to_e0", 8'hE0, 0);
    for (int k = 1; k <= T + 1; k++) begin
      apply(1'b0, 1'b0, 8'h00);
      check("to_wait", k, (k == T) ? 6'b000001 : 6'b000000);
    end
    send("to_plain75", 8'h75, 0);

    // timeout from ST_BREAK keeps held keys
    send("tob_make", 8'h29, 6'b001000);
    send("tob_f0", 8'hF0, 6'b001000);
    for (int k = 1; k <= T; k++) begin
      apply(1'b0, 1'b0, 8'h00);
      check("tob_wait", k, (k == T) ? 6'b001001 : 6'b001000);
    end
    idle("tob_after", 6'b001000);
    send("tob_f0b", 8'hF0, 6'b001000);
    send("tob_rel", 8'h29, 0);

    // byte in the expiry cycle is processed, no seq_err
    send("edge_e0", 8'hE0, 0);
    for (int k = 1; k < T; k++) idle("edge_wait", 0);
    send("edge_6b", 8'h6B, 6'b100000);
    send("edge_r0", 8'hE0, 6'b100000);
    send("edge_r1", 8'hF0, 6'b100000);
    send("edge_r2", 8'h6B, 0);

    // a second E0 restarts the wait
    send("rs_e0", 8'hE0, 0);
    for (int k = 0; k < 10; k++) idle("rs_wait_a", 0);
    send("rs_e0b", 8'hE0, 0);
    for (int k = 0; k < 10; k++) idle("rs_wait_b", 0);
    send("rs_6b", 8'h6B, 6'b100000);
    send("rs_r0", 8'hE0, 6'b100000);
    send("rs_r1", 8'hF0, 6'b100000);
    send("rs_r2", 8'h6B, 0);

    // reset mid-sequence, with a key held
    send("rm_make", 8'h29, 6'b001000);
    send("rm_e0", 8'hE0, 6'b001000);
    pulse_reset("rm_async");
    send("rm_6b", 8'h6B, 0);

`ifdef DONKEY_KEY_WASD_EN
    send("wasd_a", 8'h1C, 6'b100000);
    send("wasd_e0", 8'hE0, 6'b100000);
    send("wasd_6b", 8'h6B, 6'b100000);
    send("wasd_f0", 8'hF0, 6'b100000);
    send("wasd_rel_a", 8'h1C, 6'b100000);
    send("wasd_e0b", 8'hE0, 6'b100000);
    send("wasd_f0b", 8'hF0, 6'b100000);
    send("wasd_rel_l", 8'h6B, 0);
    send("wasd_w", 8'h1D, 6'b000100);
    send("wasd_s", 8'h1B, 6'b000110);
    send("wasd_d", 8'h23, 6'b010110);
    add(1, 0, 8'h00, 0);
    apply(1'b1, 1'b0, 8'h00);
    check("wasd_clr", 0, 0);
`else
    send("nowasd_a", 8'h1C, 0);
    send("nowasd_d", 8'h23, 0);
    send("nowasd_w", 8'h1D, 0);
    send("nowasd_s", 8'h1B, 0);
`endif

    // randomized stream vs reference model
    pulse_reset("rand_reset");
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        apply(1'b1, ($urandom_range(0, 1) == 1), pool[$urandom_range(0, 11)]);
        check("rand_clr", n, model_out());
      end else if (r < 5) begin
        int gap;
        gap = $urandom_range(10, 20);
        for (int g = 0; g < gap; g++) begin
          apply(1'b0, 1'b0, 8'h00);
          check("rand_gap", n, model_out());
        end
      end else if (r == 5) begin
        pulse_reset("rand_rst");
      end else if (r < 50) begin
        int sel;
        logic [7:0] d;
        sel = $urandom_range(0, 12);
        d   = (sel == 12) ? 8'($urandom) : pool[sel];
        apply(1'b0, 1'b1, d);
        check("rand_byte", n, model_out());
      end else begin
        apply(1'b0, 1'b0, 8'h00);
        check("rand_idle", n, model_out());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
